// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and byte-lane helpers for the MEM-stage load/store unit
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // The low two funct3 bits encode access size for both signed and unsigned forms.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects the addressed lane of a read word and sign/zero-extends it
module load_formatter
    import mem_lsu_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] rdata_i,
    input  logic [1:0]           off_i,
    input  logic [2:0]           funct3_i,
    output logic [DATA_SIZE-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{(DATA_SIZE-8){byte_v[7]}}, byte_v};
            F3_BU:   data_o = {{(DATA_SIZE-8){1'b0}}, byte_v};
            F3_H:    data_o = {{(DATA_SIZE-16){half_v[15]}}, half_v};
            F3_HU:   data_o = {{(DATA_SIZE-16){1'b0}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/ack data-memory access, stall and load formatting
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 mem_read_mem,
    input  logic                 mem_write_mem,
    input  logic [2:0]           inst_14_to_12_mem,
    input  logic [DATA_SIZE-1:0] address_alu_result_mem,
    input  logic [DATA_SIZE-1:0] read_data_2_mem,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [DATA_SIZE-1:0] dmem_wdata,
    input  logic [DATA_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 stall_mem,
    output logic [DATA_SIZE-1:0] load_data_mem,
    output logic                 load_valid_mem,
    output logic                 access_fault_mem
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_t           state_q;
    logic [CW-1:0]        cnt_q;
    logic                 req_q, we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [3:0]           be_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [1:0]           off_q;
    logic [2:0]           f3_q;
    logic [DATA_SIZE-1:0] ld_data_q;
    logic                 ld_valid_q, fault_q;

    logic                 access, ok, issue;
    logic [1:0]           off_d;
    logic [DATA_SIZE-1:0] fmt_data;
    logic                 unused_addr_bits;

    assign off_d  = address_alu_result_mem[1:0];
    assign access = mem_read_mem | mem_write_mem;
    assign ok     = f3_legal(inst_14_to_12_mem) &&
                    !misaligned(inst_14_to_12_mem[1:0], off_d);
    assign issue  = (state_q == IDLE) && access && ok;

    // Combinational so the issuing cycle already freezes the upstream stages.
    assign stall_mem = clear_n && ((state_q == BUSY) || issue);

    assign unused_addr_bits = ^address_alu_result_mem[DATA_SIZE-1:ADDR_SIZE+2];

    load_formatter #(.DATA_SIZE(DATA_SIZE)) u_fmt (
        .rdata_i  (dmem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (fmt_data)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write_mem;
                        addr_q  <= address_alu_result_mem[ADDR_SIZE+1:2];
                        be_q    <= byte_en(inst_14_to_12_mem[1:0], off_d);
                        wdata_q <= lane_rep(inst_14_to_12_mem[1:0], read_data_2_mem);
                        off_q   <= off_d;
                        f3_q    <= inst_14_to_12_mem;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end else if (access) begin
                        fault_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        if (!we_q) begin
                            ld_data_q  <= fmt_data;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT-1)) begin
                        req_q     <= 1'b0;
                        ld_data_q <= '0;
                        fault_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign load_data_mem    = ld_data_q;
    assign load_valid_mem   = ld_valid_q;
    assign access_fault_mem = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        mem_read_mem, mem_write_mem;
    logic [2:0]  inst_14_to_12_mem;
    logic [31:0] address_alu_result_mem, read_data_2_mem;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_mem;
    logic [31:0] load_data_mem;
    logic        load_valid_mem, access_fault_mem;

    mem_stage_lsu #(.DATA_SIZE(32), .ADDR_SIZE(10), .TIMEOUT(TIMEOUT)) dut (
        .clk                    (clk),
        .clear_n                (clear_n),
        .mem_read_mem           (mem_read_mem),
        .mem_write_mem          (mem_write_mem),
        .inst_14_to_12_mem      (inst_14_to_12_mem),
        .address_alu_result_mem (address_alu_result_mem),
        .read_data_2_mem        (read_data_2_mem),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_be                (dmem_be),
        .dmem_wdata             (dmem_wdata),
        .dmem_rdata             (dmem_rdata),
        .dmem_ack               (dmem_ack),
        .stall_mem              (stall_mem),
        .load_data_mem          (load_data_mem),
        .load_valid_mem         (load_valid_mem),
        .access_fault_mem       (access_fault_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic        valid;
        logic        chk_data;
        logic [31:0] data;
    } res_t;

    res_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_ld;
    logic [9:0]  last_addr;
    logic [3:0]  last_be;
    logic        last_we;
    logic [31:0] last_wdata;
    int          last_stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_legal(input logic [2:0] f3);
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == 3'd1 || f3 == 3'd5) && off[0]) || (f3 == 3'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd2) return 4'hF;
        if (f3 == 3'd1 || f3 == 3'd5) return off[1] ? 4'b1100 : 4'b0011;
        case (off)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd2) return d;
        if (f3 == 3'd1 || f3 == 3'd5) return (d & 32'hFFFF) * 32'h0001_0001;
        return (d & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (f3)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd4:    return sh & 32'hFF;
            3'd1:    return 32'($signed(sh[15:0]));
            3'd5:    return sh & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (clear_n && (load_valid_mem || access_fault_mem)) begin
            if (load_valid_mem) last_ld = load_data_mem;
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("res_fault", access_fault_mem, r.fault);
                check("res_valid", load_valid_mem, r.valid);
                if (r.chk_data) check("res_data", load_data_mem, r.data);
            end
        end
    end

    // ack_dly: BUSY cycle on which to ack (0 = never ack).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int ack_dly);
        logic ok, s, done;
        int   stalls, busy, exp_stalls, exp_busy;
        res_t r;
        ok = m_legal(f3) && !m_misal(f3, a[1:0]);
        if (!ok) begin
            r = '{fault: 1'b1, valid: 1'b0, chk_data: 1'b0, data: 32'd0};
            sb.push_back(r);
        end else if (ack_dly == 0) begin
            r = '{fault: 1'b1, valid: 1'b0, chk_data: 1'b1, data: 32'd0};
            sb.push_back(r);
        end else if (!wr) begin
            r = '{fault: 1'b0, valid: 1'b1, chk_data: 1'b1, data: m_load(f3, a[1:0], rdat)};
            sb.push_back(r);
        end
        exp_busy   = !ok ? 0 : (ack_dly == 0 ? TIMEOUT : ack_dly);
        exp_stalls = !ok ? 0 : 1 + exp_busy;

        @(negedge clk);
        mem_read_mem = rd; mem_write_mem = wr; inst_14_to_12_mem = f3;
        address_alu_result_mem = a; read_data_2_mem = wd;
        #1;
        stalls = 0; busy = 0; done = 1'b0;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            s = stall_mem;
            if (s) stalls++;
            if (dmem_req) begin
                busy++;
                if (busy == 1) begin
                    last_addr = dmem_addr; last_be = dmem_be;
                    last_we = dmem_we; last_wdata = dmem_wdata;
                    check("req_we", dmem_we, wr);
                    check("req_addr", dmem_addr, a[11:2]);
                    check("req_be", dmem_be, m_be(f3, a[1:0]));
                    if (wr) check("req_wdata", dmem_wdata, m_wdata(f3, wd));
                end else begin
                    check("req_stable", {dmem_addr, dmem_be}, {last_addr, last_be});
                end
                if (busy == ack_dly) begin
                    dmem_ack = 1'b1; dmem_rdata = rdat;
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!s) begin done = 1'b1; break; end
        end
        mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        if (!done) check("cycle_budget", 32'd0, 32'd1);
        check("stall_cycles", stalls, exp_stalls);
        check("req_cycles", busy, exp_busy);
        last_stalls = stalls;
    endtask

    initial begin
        clear_n = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0;
        inst_14_to_12_mem = 3'd0; address_alu_result_mem = 32'd0;
        read_data_2_mem = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", stall_mem, 1'b0);
        check("rst_valid", load_valid_mem, 1'b0);
        check("rst_fault", access_fault_mem, 1'b0);
        check("rst_data", load_data_mem, 32'd0);
        clear_n = 1'b1;

        do_access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 3);
        check("sw_addr", last_addr, 32'd4);
        check("sw_be", last_be, 32'hF);
        check("sw_we", last_we, 1'b1);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_stall4", last_stalls, 32'd4);

        do_access(1'b1, 1'b0, 3'd0, 32'h13, 32'd0, 32'h80123456, 1);
        check("lb_const", last_ld, 32'hFFFFFF80);
        check("lb_min_stall", last_stalls, 32'd2);
        do_access(1'b1, 1'b0, 3'd4, 32'h13, 32'd0, 32'h80123456, 2);
        check("lbu_const", last_ld, 32'h00000080);

        do_access(1'b0, 1'b1, 3'd1, 32'h06, 32'h1234ABCD, 32'd0, 1);
        check("sh_be", last_be, 32'hC);
        check("sh_wdata", last_wdata, 32'hABCDABCD);
        do_access(1'b1, 1'b0, 3'd5, 32'h06, 32'd0, 32'hABCD0000, 1);
        check("lhu_const", last_ld, 32'h0000ABCD);

        do_access(1'b1, 1'b0, 3'd2, 32'h02, 32'd0, 32'd0, 1);
        do_access(1'b1, 1'b0, 3'd3, 32'h20, 32'd0, 32'd0, 1);
        do_access(1'b0, 1'b1, 3'd6, 32'h20, 32'd0, 32'd0, 1);
        do_access(1'b1, 1'b0, 3'd1, 32'h21, 32'd0, 32'd0, 1);
        do_access(1'b0, 1'b1, 3'd4, 32'h21, 32'h00000055, 32'd0, 2);
        check("sbu_be", last_be, 32'h2);
        do_access(1'b1, 1'b1, 3'd2, 32'h28, 32'hCAFEF00D, 32'hFFFFFFFF, 1);
        check("rdwr_we", last_we, 1'b1);

        do_access(1'b1, 1'b0, 3'd2, 32'h30, 32'd0, 32'd0, 0);

        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_ack_valid", load_valid_mem, 1'b0);
        check("idle_ack_req", dmem_req, 1'b0);

        @(negedge clk);
        mem_read_mem = 1'b1; inst_14_to_12_mem = 3'd2; address_alu_result_mem = 32'h40;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_req", dmem_req, 1'b1);
        clear_n = 1'b0;
        #1;
        check("async_rst_req", dmem_req, 1'b0);
        check("async_rst_stall", stall_mem, 1'b0);
        mem_read_mem = 1'b0;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", dmem_req, 1'b0);
        check("post_rst_stall", stall_mem, 1'b0);
        do_access(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, 32'h0BADF00D, 2);
        check("post_rst_lw", last_ld, 32'h0BADF00D);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic        w;
            case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            a = $urandom & 32'h0000_0FFF;
            if (f3 == 3'd2) a[1:0] = 2'b00;
            if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            w = ($urandom_range(0, 2) == 0);
            do_access(!w, w, f3, a, $urandom, $urandom, $urandom_range(1, 5));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
